// File: rtl/counter_two_digit.sv
// Free-running two-digit BCD up-counter (dig1 = tens, dig0 = units) that wraps at MODULO.
// Define COUNTER_TWO_DIGIT_TC_EN to add the registered terminal-count output tc.
module counter_two_digit #(
  parameter int MODULO = 100
) (
  input  logic       clock,
  input  logic       reset,
`ifdef COUNTER_TWO_DIGIT_TC_EN
  output logic       tc,
`endif
  output logic [3:0] dig1,
  output logic [3:0] dig0
);

  generate
    if (MODULO < 2 || MODULO > 100) begin : g_bad_modulo
      $error("counter_two_digit: MODULO must lie in 2..100");
    end
  endgenerate

  localparam logic [7:0] LAST_VALUE = 8'(MODULO - 1);
  localparam logic [3:0] LAST_TENS  = 4'((MODULO - 1) / 10);
  localparam logic [3:0] LAST_UNITS = 4'((MODULO - 1) % 10);

  logic [7:0] value;
  logic       illegal;
  logic [3:0] next_dig1;
  logic [3:0] next_dig0;

  // Digits above 9 or a value beyond the modulus (e.g. after an upset) recover to 00.
  assign value   = ({4'd0, dig1} * 8'd10) + {4'd0, dig0};
  assign illegal = (dig1 > 4'd9) || (dig0 > 4'd9) || (value > LAST_VALUE);

  always_comb begin
    next_dig1 = dig1;
    next_dig0 = dig0 + 4'd1;
    if (illegal || value == LAST_VALUE) begin
      next_dig1 = 4'd0;
      next_dig0 = 4'd0;
    end else if (dig0 == 4'd9) begin
      next_dig1 = dig1 + 4'd1;
      next_dig0 = 4'd0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dig1 <= 4'd0;
      dig0 <= 4'd0;
    end else begin
      dig1 <= next_dig1;
      dig0 <= next_dig0;
    end
  end

`ifdef COUNTER_TWO_DIGIT_TC_EN
  // tc is registered alongside the digits so it is high exactly while they show the last value.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tc <= 1'b0;
    end else begin
      tc <= (next_dig1 == LAST_TENS) && (next_dig0 == LAST_UNITS);
    end
  end
`else
  logic unused_last;
  assign unused_last = ^{LAST_TENS, LAST_UNITS};
`endif

endmodule

// File: tb/tb_counter_two_digit.sv
// Self-checking bench: MODULO=100 and MODULO=60 instances against an arithmetic counter model.
module tb_counter_two_digit;

  logic       clock;
  logic       reset;
  logic [3:0] dig1_a, dig0_a;
  logic [3:0] dig1_b, dig0_b;
`ifdef COUNTER_TWO_DIGIT_TC_EN
  logic       tc_a, tc_b;
`endif

  int compared   = 0;
  int mismatched = 0;
  int model_a    = 0;
  int model_b    = 0;

  counter_two_digit #(.MODULO(100)) dut_a (
    .clock (clock),
    .reset (reset),
`ifdef COUNTER_TWO_DIGIT_TC_EN
    .tc    (tc_a),
`endif
    .dig1  (dig1_a),
    .dig0  (dig0_a)
  );

  counter_two_digit #(.MODULO(60)) dut_b (
    .clock (clock),
    .reset (reset),
`ifdef COUNTER_TWO_DIGIT_TC_EN
    .tc    (tc_b),
`endif
    .dig1  (dig1_b),
    .dig0  (dig0_b)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  // Reference: plain modular arithmetic on an integer count.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      model_a = 0;
      model_b = 0;
    end else begin
      model_a = (model_a + 1) % 100;
      model_b = (model_b + 1) % 60;
    end
  end

  task automatic compare_one(input string name, input logic [3:0] d1, input logic [3:0] d0,
                             input int expected);
    compared++;
    if (d1 !== 4'(expected / 10) || d0 !== 4'(expected % 10) || d1 > 4'd9 || d0 > 4'd9) begin
      mismatched++;
      $display("[TB] FAIL %s at %0t: got %0d%0d expected %0d", name, $time, d1, d0, expected);
    end
  endtask

  // Every falling edge is away from the active edge and from reset changes.
  always @(negedge clock) begin
    compare_one("cycle_a", dig1_a, dig0_a, model_a);
    compare_one("cycle_b", dig1_b, dig0_b, model_b);
`ifdef COUNTER_TWO_DIGIT_TC_EN
    compared++;
    if (tc_a !== (model_a == 99) || tc_b !== (model_b == 59)) begin
      mismatched++;
      $display("[TB] FAIL cycle_tc at %0t: got %0b/%0b expected %0b/%0b", $time, tc_a, tc_b,
               model_a == 99, model_b == 59);
    end
`endif
  end

  task automatic checkOutput(input string name, input int exp_a, input int exp_b);
    compare_one({name, "_a"}, dig1_a, dig0_a, exp_a);
    compare_one({name, "_b"}, dig1_b, dig0_b, exp_b);
    compared++;
    if (model_a != exp_a || model_b != exp_b) begin
      mismatched++;
      $display("[TB] FAIL %s_model: got %0d/%0d expected %0d/%0d", name, model_a, model_b,
               exp_a, exp_b);
    end
  endtask

  task automatic applyStimulus(input int edges);
    repeat (edges) @(posedge clock);
    #1;
  endtask

  task automatic pulse_reset(input int hold_ns);
    @(posedge clock);
    #5 reset = 1'b0;
    #1;
    compare_one("async_reset_a", dig1_a, dig0_a, 0);
    compare_one("async_reset_b", dig1_b, dig0_b, 0);
    #(hold_ns);
    @(posedge clock);
    #7 reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    #50;
    checkOutput("powerup_mid", 0, 0);
    #50;
    checkOutput("powerup_end", 0, 0);

    @(posedge clock);
    #7 reset = 1'b1;
    applyStimulus(1);
    checkOutput("first_edge", 1, 1);
    applyStimulus(8);
    checkOutput("units_nine", 9, 9);
    applyStimulus(1);
    checkOutput("decimal_carry", 10, 10);
    applyStimulus(49);
    checkOutput("b_last", 59, 59);
`ifdef COUNTER_TWO_DIGIT_TC_EN
    compared++;
    if (tc_b !== 1'b1 || tc_a !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL tc_at_59: got %0b/%0b expected 0/1", tc_a, tc_b);
    end
`endif
    applyStimulus(1);
    checkOutput("b_wrap", 60, 0);
    applyStimulus(39);
    checkOutput("a_last", 99, 39);
`ifdef COUNTER_TWO_DIGIT_TC_EN
    compared++;
    if (tc_a !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL tc_at_99: got %0b expected 1", tc_a);
    end
`endif
    applyStimulus(1);
    checkOutput("a_wrap", 0, 40);

    applyStimulus(41);
    checkOutput("before_mid_reset", 41, 21);
    pulse_reset(100);
    #1;
    checkOutput("held_reset", 0, 0);
    applyStimulus(50);
    checkOutput("after_release", 50, 50);

    for (int i = 0; i < 25; i++) begin
      applyStimulus($urandom_range(1, 160));
      pulse_reset($urandom_range(0, 60));
    end
    applyStimulus(130);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
